mips_imem_loader: RTL

//  Boot-time program loader sitting upstream of the single-cycle MIPS core.

---
 rtl/mips_imem_loader_pkg.sv | 22 ++
 rtl/mips_imem_loader_if.sv | 22 ++
 rtl/mips_byte_packer.sv | 49 ++++
 rtl/mips_imem_loader.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mips_imem_loader_pkg.sv
// rtl/mips_imem_loader_pkg.sv - shared types and sizing helpers for the MIPS instruction-memory loader
package mips_imem_loader_pkg;

   // Loader FSM states; CSUM is only reachable with MIPS_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      LEN0 = 3'd0,
      LEN1 = 3'd1,
      DATA = 3'd2,
      CSUM = 3'd3,
      DONE = 3'd4,
      ERR  = 3'd5
   } t_ldr_state;

   localparam int IMEM_BYTES_DEF = 128;
   localparam int LEN_W_DEF      = 16;

   // Byte-address width for an instruction memory of the given size
   function automatic int addr_w(input int bytes);
      return $clog2(bytes);
   endfunction

endpackage

// File: rtl/mips_imem_loader_if.sv
// rtl/mips_imem_loader_if.sv - byte stream in, instruction-memory write port out
interface mips_imem_loader_if #(
   parameter int AW = 7
) ();
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    in_data;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;

   // master: the loader; slave: the byte source / memory side
   modport master (
      input  in_valid, in_data,
      output in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      output in_valid, in_data,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/mips_byte_packer.sv
// rtl/mips_byte_packer.sv - packs accepted bytes into little-endian 32-bit words
module mips_byte_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        take,
   input  logic [7:0]  data,
   output logic        word_complete,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [31:0] word_q, word_d;
   logic        word_valid_q, word_valid_d;

   // Bytes shift in from the top so the first byte ends up in word[7:0]
   always_comb begin
      byte_cnt_d   = byte_cnt_q;
      word_d       = word_q;
      word_valid_d = 1'b0;
      if (clr) begin
         byte_cnt_d = 2'd0;
         word_d     = 32'd0;
      end else if (take) begin
         byte_cnt_d   = byte_cnt_q + 2'd1;
         word_d       = {data, word_q[31:8]};
         word_valid_d = (byte_cnt_q == 2'd3);
      end
   end

   // Packer state; a partial word is simply dropped on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt_q   <= 2'd0;
         word_q       <= 32'd0;
         word_valid_q <= 1'b0;
      end else begin
         byte_cnt_q   <= byte_cnt_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
      end
   end

   assign word_complete = take && (byte_cnt_q == 2'd3);
   assign word_valid    = word_valid_q;
   assign word          = word_q;

endmodule

// File: rtl/mips_imem_loader.sv
// rtl/mips_imem_loader.sv - boot loader writing a streamed image into IMEM; MIPS_LOADER_CHECKSUM_EN adds an XOR checksum byte
module mips_imem_loader
   import mips_imem_loader_pkg::*;
#(
   parameter  int IMEM_BYTES = IMEM_BYTES_DEF,
   parameter  int LEN_W      = LEN_W_DEF,
   localparam int AW         = addr_w(IMEM_BYTES)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 reload,
   mips_imem_loader_if.master   bus,
   output logic                 cpu_rst,
   output logic                 load_done,
   output logic                 load_err
);

   localparam logic [LEN_W-1:0] MAX_WORDS = LEN_W'(IMEM_BYTES / 4);

   t_ldr_state       state_q, state_d;
   logic [7:0]       len_lo_q, len_lo_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [AW-3:0]    word_idx_q, word_idx_d;
   logic [AW-1:0]    imem_addr_q, imem_addr_d;
   logic             in_ready_q, in_ready_d;
   logic             cpu_rst_q, cpu_rst_d;
   logic             load_done_q, load_done_d;
   logic             load_err_q, load_err_d;
`ifdef MIPS_LOADER_CHECKSUM_EN
   logic [7:0]       xor_q, xor_d;
`endif

   logic             accept;
   logic             pk_take;
   logic             pk_clr;
   logic             pk_complete;
   logic             pk_valid;
   logic [31:0]      pk_word;
   logic [LEN_W-1:0] hdr_len;

   assign accept  = bus.in_valid && in_ready_q;
   assign pk_take = accept && (state_q == DATA);
   assign pk_clr  = reload && ((state_q == DONE) || (state_q == ERR));
   assign hdr_len = LEN_W'({bus.in_data, len_lo_q});

   mips_byte_packer u_packer (
      .clk           (clk),
      .rst           (rst),
      .clr           (pk_clr),
      .take          (pk_take),
      .data          (bus.in_data),
      .word_complete (pk_complete),
      .word_valid    (pk_valid),
      .word          (pk_word)
   );

   // Next state, addressing and registered status outputs
   always_comb begin
      state_d     = state_q;
      len_lo_d    = len_lo_q;
      len_d       = len_q;
      word_idx_d  = word_idx_q;
      imem_addr_d = imem_addr_q;
`ifdef MIPS_LOADER_CHECKSUM_EN
      xor_d       = xor_q;
`endif
      case (state_q)
         LEN0: begin
            if (accept) begin
               len_lo_d = bus.in_data;
               state_d  = LEN1;
            end
         end
         LEN1: begin
            if (accept) begin
               len_d = hdr_len;
               if (hdr_len == '0) begin
`ifdef MIPS_LOADER_CHECKSUM_EN
                  state_d = CSUM;
`else
                  state_d = DONE;
`endif
               end else if (hdr_len > MAX_WORDS) begin
                  state_d = ERR;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (pk_take) begin
`ifdef MIPS_LOADER_CHECKSUM_EN
               xor_d = xor_q ^ bus.in_data;
`endif
               if (pk_complete) begin
                  imem_addr_d = {word_idx_q, 2'b00};
                  word_idx_d  = word_idx_q + (AW-2)'(1);
                  if ((LEN_W'(word_idx_q) + LEN_W'(1)) == len_q) begin
`ifdef MIPS_LOADER_CHECKSUM_EN
                     state_d = CSUM;
`else
                     state_d = DONE;
`endif
                  end
               end
            end
         end
`ifdef MIPS_LOADER_CHECKSUM_EN
         CSUM: begin
            if (accept) begin
               state_d = (xor_q == bus.in_data) ? DONE : ERR;
            end
         end
`endif
         DONE, ERR: begin
            if (reload) begin
               state_d     = LEN0;
               len_lo_d    = 8'd0;
               len_d       = '0;
               word_idx_d  = '0;
               imem_addr_d = '0;
`ifdef MIPS_LOADER_CHECKSUM_EN
               xor_d       = 8'd0;
`endif
            end
         end
         default: state_d = LEN0;
      endcase

      in_ready_d  = (state_d != DONE) && (state_d != ERR);
      load_done_d = (state_d == DONE);
      load_err_d  = (state_d == ERR);
      // Core leaves reset only on the second DONE cycle, after the last write
      cpu_rst_d   = !((state_q == DONE) && (state_d == DONE));
   end

   // Loader registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= LEN0;
         len_lo_q    <= 8'd0;
         len_q       <= '0;
         word_idx_q  <= '0;
         imem_addr_q <= '0;
         in_ready_q  <= 1'b0;
         cpu_rst_q   <= 1'b1;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
`ifdef MIPS_LOADER_CHECKSUM_EN
         xor_q       <= 8'd0;
`endif
      end else begin
         state_q     <= state_d;
         len_lo_q    <= len_lo_d;
         len_q       <= len_d;
         word_idx_q  <= word_idx_d;
         imem_addr_q <= imem_addr_d;
         in_ready_q  <= in_ready_d;
         cpu_rst_q   <= cpu_rst_d;
         load_done_q <= load_done_d;
         load_err_q  <= load_err_d;
`ifdef MIPS_LOADER_CHECKSUM_EN
         xor_q       <= xor_d;
`endif
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.imem_we    = pk_valid;
   assign bus.imem_addr  = imem_addr_q;
   assign bus.imem_wdata = pk_word;
   assign cpu_rst        = cpu_rst_q;
   assign load_done      = load_done_q;
   assign load_err       = load_err_q;

endmodule
